// File: rtl/tri_arb_pkg.sv
// Shared types and sizing helpers for the tri-state bus arbiter.
// The hold-limit feature is selected by the TRI_ARB_HOLD_LIMIT_EN macro in tri_bus_arbiter.
package tri_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  localparam int DEF_N = 4;

  // Index width; never below one bit so the owner port always exists.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int OWNER_W = owner_w(DEF_N);

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting just after 'last',
// wrapping, and returns the first set bit as one-hot, index and valid.
module rr_pick
  import tri_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = owner_w(DEF_N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  oh_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  int j;

  always_comb begin
    oh_o  = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last_i) + i) % N;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        oh_o[j]  = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with a one-cycle turnaround between owners.
// Define TRI_ARB_HOLD_LIMIT_EN to force the owner off after MAX_HOLD cycles under contention.
module tri_bus_arbiter
  import tri_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  output logic [N-1:0]            grant,
  output logic [N-1:0]            oe,
  output logic [owner_w(N)-1:0]   owner,
  output logic                    bus_z
);

  localparam int IW = owner_w(N);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic          bus_z_q;
  logic          rel;

  logic [N-1:0]  pick_oh;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;

`ifdef TRI_ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
`else
  // MAX_HOLD only has meaning when the hold limit is compiled in.
  if (MAX_HOLD < 1) begin : g_max_hold_unused
  end
`endif

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .oh_o   (pick_oh),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    rel     = 1'b0;
`ifdef TRI_ARB_HOLD_LIMIT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      ST_OWN: begin
        rel = ~req[owner_q];
`ifdef TRI_ARB_HOLD_LIMIT_EN
        if ((hold_q == HW'(MAX_HOLD)) && (|(req & ~grant_q))) rel = 1'b1;
`endif
        if (rel) begin
          grant_d = '0;
          owner_d = '0;
          state_d = ST_TURN;
        end
`ifdef TRI_ARB_HOLD_LIMIT_EN
        else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: begin
        // IDLE and TURN both arbitrate; TURN has already spent its released cycle.
        grant_d = '0;
        owner_d = '0;
        state_d = ST_IDLE;
        if (pick_vld) begin
          grant_d = pick_oh;
          owner_d = pick_idx;
          last_d  = pick_idx;
          state_d = ST_OWN;
`ifdef TRI_ARB_HOLD_LIMIT_EN
          hold_d  = HW'(1);
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(N - 1);
      bus_z_q <= 1'b1;
`ifdef TRI_ARB_HOLD_LIMIT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bus_z_q <= ~|grant_d;
`ifdef TRI_ARB_HOLD_LIMIT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign grant = grant_q;
  assign oe    = grant_q;
  assign owner = owner_q;
  assign bus_z = bus_z_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (N=4, MAX_HOLD=4); contention expectations
// follow whether TRI_ARB_HOLD_LIMIT_EN is defined.
module tb_tri_bus_arbiter;
  import tri_arb_pkg::*;

  localparam int N  = 4;
  localparam int MH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req;
  logic [N-1:0]       grant;
  logic [N-1:0]       oe;
  logic [OWNER_W-1:0] owner;
  logic               bus_z;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tri_bus_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .oe    (oe),
    .owner (owner),
    .bus_z (bus_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check the output invariants away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk("oe_le1", 32'($countones(oe) <= 1), 32'd1);
    chk("oe_eq_grant", 32'(oe), 32'(grant));
    chk("bus_z_eq", 32'(bus_z), 32'(oe == '0));
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_oe", 32'(oe), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_bus_z", 32'(bus_z), 32'h1);

    rst = 1'b0;
    step();
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_owner", 32'(owner), 32'h0);

    req = 4'b0000;
    step();
    chk("first_rel", 32'(grant), 32'h0);
    step();
    chk("first_idle", 32'(grant), 32'h0);

    // Single requester 2, high for three edges.
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("single_grant", 32'(grant), 32'h4);
      chk("single_owner", 32'(owner), 32'h2);
    end
    req = 4'b0000;
    step();
    chk("single_turn_oe", 32'(oe), 32'h0);
    chk("single_turn_bz", 32'(bus_z), 32'h1);
    chk("single_turn_owner", 32'(owner), 32'h0);
    step();
    chk("single_idle", 32'(grant), 32'h0);

`ifdef TRI_ARB_HOLD_LIMIT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < MH; c++) begin
        step();
        chk("cont_grant", 32'(grant), 32'(1) << (k % 4));
        chk("cont_owner", 32'(owner), 32'(k % 4));
      end
      step();
      chk("cont_turn", 32'(grant), 32'h0);
    end
`else
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0011;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("nohold_grant", 32'(grant), 32'h1);
    end
`endif

    // Handover: owner 1 drops while requester 3 rises on the same edge.
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    req = 4'b0010;
    step();
    chk("ho_own1", 32'(grant), 32'h2);
    chk("ho_owner1", 32'(owner), 32'h1);
    step();
    chk("ho_hold1", 32'(grant), 32'h2);
    req = 4'b1000;
    step();
    chk("ho_turn", 32'(oe), 32'h0);
    step();
    chk("ho_own3", 32'(grant), 32'h8);
    chk("ho_owner3", 32'(owner), 32'h3);

    // Reset while requester 2 owns the bus.
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    req = 4'b0100;
    step();
    chk("mid_own2", 32'(owner), 32'h2);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_oe", 32'(oe), 32'h0);
    chk("mid_rst_owner", 32'(owner), 32'h0);
    rst = 1'b0;
    req = 4'b0101;
    step();
    chk("mid_after_grant", 32'(grant), 32'h1);
    chk("mid_after_owner", 32'(owner), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Round-robin arbiter that shares one tri-state bus among N requesters. It is the controller for the per-requester tri-state buffer enables. It guarantees at most one driver is enabled at any time and inserts a one-cycle all-released turnaround between owners so two drivers never overlap. An optional hold-time limit forces the current owner off the bus when others are waiting.

## Interface
- N, default 4: number of requesters, N ≥ 2.
- MAX_HOLD, default 8: maximum consecutive owned cycles when contention exists, ≥ 1. Only used when the hold limit is compiled in.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  request per requester; the requester holds it high for as long as it needs the bus.
- grant  out  N  one-hot or zero; registered ownership.
- oe  out  N  tri-state enable per requester; equals grant.
- owner  out  $clog2(N)  index of the current owner; 0 when no owner.
- bus_z  out  1  high when no oe bit is set (bus floating).

## Operation
- States: IDLE, OWN, TURN.
- Round-robin pick:
  - Scan req starting at (last+1) mod N, wrapping, and take the first set bit.
  - last updates to the winner's index at every grant.
- IDLE:
  - grant = 0.
  - If req ≠ 0: grant and oe ← onehot(pick), owner ← pick, hold_cnt ← 1, go to OWN.
- OWN:
  - Release when req[owner] is 0, or when the hold limit is hit (hold_cnt == MAX_HOLD and (req & ~grant) ≠ 0).
  - Release means grant, oe ← 0 and go to TURN.
  - Otherwise stay in OWN. hold_cnt increments and saturates at MAX_HOLD.
- TURN:
  - grant = 0 for exactly one cycle.
  - Then arbitrate as in IDLE. If req == 0, go to IDLE.
  - Back-to-back ownership by the same requester is allowed only when it is the sole requester.
- Invariants:
  - popcount(oe) ≤ 1 at all times.
  - Any owner change always passes through at least one cycle with oe == 0.
- Requests that drop before being granted are forgotten; there is no queuing.

## Timing
- All outputs are registered.
- Reset values:
  - grant = 0, oe = 0, owner = 0, bus_z = 1.
  - State = IDLE, last = N-1, so requester 0 wins first. hold_cnt = 0.
- rst has priority over every other event. Asserting it mid-ownership clears oe at that edge, with no turnaround.
- Grant latency: req is sampled high at edge k in IDLE, and grant is visible after edge k (1 cycle).
- Release latency: req[owner] is sampled low at edge k, and oe is 0 after edge k.
- Handover under contention: owner released at edge k, TURN during the cycle after, new grant after edge k+1.
- Period under full contention with the hold limit is MAX_HOLD + 1 cycles per owner.
- Simultaneous owner-release and new request: the new request is evaluated at the TURN edge, not earlier.
- Wrap-around: from last = N-1, the scan starts at index 0.

## Configuration
- TRI_ARB_HOLD_LIMIT_EN defined:
  - hold_cnt and the forced release are implemented as described in Operation.
- Not defined:
  - hold_cnt is removed and MAX_HOLD is ignored.
  - The owner keeps the bus until it drops req, regardless of other requests.

## Structure
- Package tri_arb_pkg holds:
  - the state encoding (IDLE=0, OWN=1, TURN=2, 2-bit);
  - the localparam for the owner index width.
- Sub-module rr_pick:
  - combinational round-robin priority picker;
  - inputs: req, last. Outputs: one-hot winner, index, valid.
- The top level holds the FSM, hold counter, last pointer and output registers.

## Test plan
All scenarios use N=4 and MAX_HOLD=4.
- Reset: rst=1 for 2 cycles with req=4'b1111 → grant=0, oe=0, bus_z=1. After release, the first grant is 4'b0001.
- Single requester: req=4'b0100 for 3 cycles, then 0 → grant=4'b0100 and owner=2 one cycle after the request, held 3 cycles. Then 1 TURN cycle with oe=0, then IDLE.
- Full contention with the macro: req=4'b1111 constant → owners 0,1,2,3,0 in sequence, each 4 cycles followed by 1 zero cycle. popcount(oe) ≤ 1 is checked every cycle.
- Handover: owner 1 drops req while req[3] rises in the same cycle → one oe=0 cycle, then grant=4'b1000.
- Without the macro: req=4'b0011 for 20 cycles → requester 0 owns all 20 cycles; requester 1 is never granted.
- Reset mid-ownership: rst pulses while owner=2 → oe=0 after that edge. With req=4'b0101 afterwards, requester 0 is granted first.
